// File: rtl/ask4_symbol_slicer.sv
// ask4_symbol_slicer
//   Receive-side 4-ASK symbol slicer. It takes the matched-filter output
//   (1s17, SPS samples per symbol) and keeps one sample per symbol at a
//   selectable phase. That sample is sliced into a Gray-coded 2-bit symbol.
//   The slicing threshold tracks the received amplitude: it is the block
//   average of |sample| over 2^LOG2_N decided symbols.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   x_in       in   receive filter output, signed 1s17, one sample per clk
//   phase      in   decimation phase select (latched at each symbol boundary)
//   sym_out    out  decided symbol, Gray coded (00,01,11,10 = -3a,-a,+a,+3a)
//   sym_valid  out  one-cycle strobe marking a new sym_out
//   ref_level  out  current threshold estimate (2a for levels +-a, +-3a)
//   sample_out out  decimated sample that produced sym_out
module ask4_symbol_slicer #(
  parameter int                 SPS      = 4,
  parameter int                 LOG2_N   = 4,
  parameter logic signed [17:0] REF_INIT = 18'sd65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [17:0]      x_in,
  input  logic [$clog2(SPS)-1:0]  phase,
  output logic [1:0]              sym_out,
  output logic                    sym_valid,
  output logic signed [17:0]      ref_level,
  output logic signed [17:0]      sample_out
);

  localparam int DATA_W = 18;
  localparam int PW     = $clog2(SPS);
  localparam int ACC_W  = DATA_W + LOG2_N;

  // |x| with the single unrepresentable case (-full scale) clamped to +full scale.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x < 0)
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

  // Four-level decision against +-r; compares are one bit wider so -r never wraps.
  function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] x,
                                       input logic signed [DATA_W-1:0] r);
    logic signed [DATA_W:0] xe;
    logic signed [DATA_W:0] re;
    xe = x;
    re = r;
    if (xe >= re)
      return 2'b10;
    else if (xe >= 0)
      return 2'b11;
    else if (xe >= -re)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  logic [PW-1:0]             cnt;
  logic [PW-1:0]             phase_r;
  logic [ACC_W-1:0]          acc;
  logic [LOG2_N-1:0]         sym_count;
  logic                      dec;
  logic [DATA_W-1:0]         ax;
  logic [ACC_W-1:0]          sum;
  logic [DATA_W-1:0]         ref_raw;
  logic signed [DATA_W-1:0]  ref_new;

  logic                      vld_p0;
  logic signed [DATA_W-1:0]  x_p0;
  logic [1:0]                sym_p0;

  always_comb begin
    dec     = (cnt == phase_r);
    ax      = abs_sat(x_in);
    sum     = acc + ACC_W'(ax);
    ref_raw = sum[ACC_W-1:LOG2_N];
    // A zero threshold would collapse the inner levels; keep at least 1 LSB.
    if (ref_raw == '0)
      ref_new = DATA_W'(1);
    else
      ref_new = $signed(ref_raw);
  end

  // Stage p0: decision edge -- capture the sample and slice it with the
  // threshold in force before this edge's possible update.
  always_ff @(posedge clk) begin
    if (dec) begin
      x_p0   <= x_in;
      sym_p0 <= slice(x_in, ref_level);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      phase_r    <= phase;
      vld_p0     <= 1'b0;
      acc        <= '0;
      sym_count  <= '0;
      ref_level  <= REF_INIT;
      sym_valid  <= 1'b0;
      sym_out    <= 2'b00;
      sample_out <= '0;
    end else begin
      cnt <= (cnt == PW'(SPS-1)) ? '0 : cnt + PW'(1);
      // Phase only moves at the window boundary, so the current window
      // always yields exactly one decision.
      if (cnt == PW'(SPS-1))
        phase_r <= phase;

      vld_p0 <= dec;
      if (dec) begin
        sym_count <= sym_count + LOG2_N'(1);
        if (sym_count == {LOG2_N{1'b1}}) begin
          ref_level <= ref_new;
          acc       <= '0;
        end else begin
          acc <= sum;
        end
      end

      // Stage p1: registered outputs, one clk after the decision edge.
      sym_valid <= vld_p0;
      if (vld_p0) begin
        sym_out    <= sym_p0;
        sample_out <= x_p0;
      end
    end
  end

endmodule
